// File: rtl/ica_ctrl_pkg.sv
// Shared types and constants for the ICA training controller: 16.16 fixed point, 2x2 matrices, FSM states.
package ica_ctrl_pkg;

   localparam int FX_W = 32;
   localparam logic [FX_W-1:0] ONE = 32'h0001_0000;

   // Entry order: [0]=B11, [1]=B12, [2]=B21, [3]=B22.
   typedef logic [3:0][FX_W-1:0] mat_t;

   localparam mat_t IDENT = {ONE, {FX_W{1'b0}}, {FX_W{1'b0}}, ONE};

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN,
      CHECK,
      DONE
   } state_t;

   function automatic logic [FX_W:0] absdiff(input logic [FX_W-1:0] a, input logic [FX_W-1:0] b);
      logic signed [FX_W:0] d;
      d = $signed({a[FX_W-1], a}) - $signed({b[FX_W-1], b});
      return d[FX_W] ? $unsigned(-d) : $unsigned(d);
   endfunction

endpackage

// File: rtl/ica_ctrl_if.sv
// Sample-source handshake and separation-core drive/readback bundle.
// master = source/core side, slave = controller.
interface ica_ctrl_if;
   import ica_ctrl_pkg::*;

   logic            smp_valid;
   logic            smp_ready;
   logic [FX_W-1:0] s1_in;
   logic [FX_W-1:0] s2_in;
   logic [FX_W-1:0] B11_in;
   logic [FX_W-1:0] B12_in;
   logic [FX_W-1:0] B21_in;
   logic [FX_W-1:0] B22_in;
   logic            core_rst;
   logic [FX_W-1:0] s1_out;
   logic [FX_W-1:0] s2_out;
   logic [FX_W-1:0] mu_out;

   modport master (
      output smp_valid, s1_in, s2_in, B11_in, B12_in, B21_in, B22_in,
      input  smp_ready, core_rst, s1_out, s2_out, mu_out
   );

   modport slave (
      input  smp_valid, s1_in, s2_in, B11_in, B12_in, B21_in, B22_in,
      output smp_ready, core_rst, s1_out, s2_out, mu_out
   );

endinterface

// File: rtl/ica_conv_chk.sv
// Convergence metric: sum of |B - Bprev| over the four entries (34-bit), saturated to 32 bits.
// Purely combinational, no handshake.
module ica_conv_chk
   import ica_ctrl_pkg::*;
(
   input  mat_t            b_cur,
   input  mat_t            b_prev,
   output logic [FX_W-1:0] delta
);

   logic [FX_W+1:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         sum = sum + {1'b0, absdiff(b_cur[i], b_prev[i])};
      end
      delta = (sum[FX_W+1:FX_W] != 2'b00) ? '1 : sum[FX_W-1:0];
   end

endmodule

// File: rtl/ica_ctrl.sv
// Training-run sequencer for a 2x2 ICA core: resets the core, streams epochs of samples, decays mu, checks B convergence.
// s_out lags an accept by 1 cycle and mu_out by 2; smp_ready is high only in RUN, and stalls drive zeros so B holds.
module ica_ctrl
   import ica_ctrl_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int EP_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [FX_W-1:0]  mu_init,
   input  logic [FX_W-1:0]  mu_min,
   input  logic [3:0]       decay_sh,
   input  logic [CNT_W-1:0] epoch_len,
   input  logic [EP_W-1:0]  max_epochs,
   input  logic [FX_W-1:0]  conv_thr,
   output logic             busy,
   output logic             done,
   output logic             converged,
   output logic [EP_W-1:0]  epoch_cnt,
   ica_ctrl_if.slave        bus
);

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       smp_cnt, len_eff;
   logic [EP_W-1:0]        max_eff, ep_inc;
   logic                   drain_2nd, accept, accept_d, last_smp, last_ep, conv_hit;
   logic [FX_W-1:0]        s1_q, s2_q, mu_q, delta;
   logic signed [FX_W-1:0] mu_cur, mu_dec, mu_nxt;
   mat_t                   b_prev, b_cur;

   assign len_eff  = (epoch_len == '0) ? CNT_W'(1) : epoch_len;
   assign max_eff  = (max_epochs == '0) ? EP_W'(1) : max_epochs;
   assign ep_inc   = epoch_cnt + EP_W'(1);
   assign last_smp = (smp_cnt == len_eff - CNT_W'(1));
   assign last_ep  = (ep_inc == max_eff);
   assign accept   = bus.smp_valid && (state == RUN);
   assign b_cur    = {bus.B22_in, bus.B21_in, bus.B12_in, bus.B11_in};
   assign conv_hit = (delta < conv_thr);
   assign mu_dec   = mu_cur - (mu_cur >>> decay_sh);
   assign mu_nxt   = (mu_dec < $signed(mu_min)) ? $signed(mu_min) : mu_dec;

   assign bus.s1_out = s1_q;
   assign bus.s2_out = s2_q;
   assign bus.mu_out = mu_q;

   ica_conv_chk u_conv_chk (
      .b_cur  (b_cur),
      .b_prev (b_prev),
      .delta  (delta)
   );

   always_comb begin
      state_nxt     = state;
      bus.smp_ready = 1'b0;
      bus.core_rst  = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && !abort) state_nxt = CLEAR;
         end
         CLEAR: begin
            bus.core_rst = 1'b1;
            state_nxt    = RUN;
         end
         RUN: begin
            bus.smp_ready = 1'b1;
            if (accept && last_smp) state_nxt = DRAIN;
         end
         DRAIN: if (drain_2nd) state_nxt = CHECK;
         CHECK: state_nxt = (conv_hit || last_ep) ? DONE : RUN;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort && (state != IDLE)) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         smp_cnt   <= '0;
         drain_2nd <= 1'b0;
         accept_d  <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         mu_q      <= '0;
         mu_cur    <= '0;
         b_prev    <= IDENT;
         epoch_cnt <= '0;
         converged <= 1'b0;
      end else begin
         // Core pipeline is s -> x -> update, so mu trails the sample by one more stage.
         accept_d <= accept;
         s1_q     <= accept ? bus.s1_in : '0;
         s2_q     <= accept ? bus.s2_in : '0;
         mu_q     <= accept_d ? mu_cur : '0;
         if ((state == IDLE) && start && !abort) begin
            converged <= 1'b0;
            epoch_cnt <= '0;
         end
         if (!abort) begin
            case (state)
               CLEAR: begin
                  mu_cur    <= mu_init;
                  smp_cnt   <= '0;
                  drain_2nd <= 1'b0;
                  b_prev    <= IDENT;
               end
               RUN: if (accept) smp_cnt <= last_smp ? '0 : smp_cnt + CNT_W'(1);
               DRAIN: drain_2nd <= ~drain_2nd;
               CHECK: begin
                  b_prev    <= b_cur;
                  epoch_cnt <= ep_inc;
                  mu_cur    <= mu_nxt;
                  if (conv_hit) converged <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
